nexys_starship_hazard_gen: RTL
==============================

# nexys_starship_hazard_gen

Hazard generator for Nexys Starship: the initiating end of the room break protocol. It decides when and where damage happens, then sends a one-cycle strike pulse plus a random nonzero repair combo to exactly one of the four room controllers (top, bottom, left, right). It skips rooms that already report broken. It sits between the game-control FSM (play/gameover) and the room FSMs, whose broken flags it reads back.

## Interface

Parameters:
- LFSR_SEED, 16'hACE1: LFSR reset value. If set to 0, the LFSR uses 16'h0001 instead.
- MIN_GAP, 2: minimum cooldown between strikes, counted in timer ticks (allowed range 1..12).
- GAP_MASK, 2'b11: mask applied to lfsr[1:0] to form the random extra gap.

Ports:
- Clk, input, 1: system clock. One clock only.
- Reset, input, 1: asynchronous, active-low reset (asserted while 0).
- play_flag, input, 1: start request from the game control FSM.
- gameover_ctrl, input, 1: game over; forces IDLE.
- timer_tick, input, 1: single-Clk-cycle enable pulse (about 1 Hz), synchronous to Clk.
- room_broken, input, 4: broken flags {RR, LR, BR, TR}, bit 0 = TR.
- room_strike, output, 4: one-hot strike pulse, same bit order as room_broken.
- strike_hex, output, 4: repair combo for the most recent strike; never 0 after the first strike.
- strike_count, output, 8: number of strikes this game; saturates at 255.
- q_Idle, q_Cool, q_Pick, q_Strike, output, 1 each: one-hot state outputs.

## Operation

LFSR:
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
- Advances every Clk cycle in every state, so player timing perturbs the sequence.

States:
- IDLE
  - Outputs: room_strike=0, strike_count=0.
  - On play_flag → COOL, and load gap_cnt = MIN_GAP + (lfsr[1:0] & GAP_MASK).
- COOL
  - On timer_tick: if gap_cnt==1 → PICK, else gap_cnt decrements. The cooldown therefore lasts exactly gap_cnt ticks.
  - Cycles without a tick change nothing.
- PICK (single-cycle decision)
  - cand = lfsr[1:0]. Target = first index with room_broken==0, searching cand, cand+1, … mod 4.
  - Found: latch target; latch strike_hex = lfsr[7:4], or 4'hF if that nibble is 0; → STRIKE.
  - room_broken==4'b1111: stay in PICK and re-evaluate every cycle until a room clears.
- STRIKE
  - room_strike = onehot(target) for this single cycle.
  - strike_count increments, saturating at 255.
  - → COOL with a fresh gap_cnt load.

Other rules:
- gameover_ctrl high in COOL/PICK/STRIKE → IDLE on the next edge, with top priority.
  - Asserted in PICK: no strike is issued and strike_hex is not updated.
  - Asserted in STRIKE: that cycle's pulse still appears, because it is decoded from the registered state.
- play_flag is ignored outside IDLE. Gameover and play asserted together in IDLE → stay IDLE.
- strike_hex holds its value between strikes and through IDLE. It is cleared only by Reset.
- Reset: state=IDLE, lfsr=seed, gap_cnt=0, target=0, strike_hex=0, strike_count=0, room_strike=0, q_Idle=1.
- Reset asserted mid-game takes effect immediately (asynchronous). No strike pulse is emitted while Reset is low.

## Timing

- All outputs are registered or decoded from registered state; no input reaches an output combinationally.
- Final tick sampled at edge t → PICK during t+1 → STRIKE (pulse visible) during t+2, provided a target is available.
- room_strike is high for exactly one Clk cycle. strike_hex is valid from the pulse cycle onward, and room FSMs sample both on the same edge.
- Minimum spacing between pulses: MIN_GAP ticks + 2 Clk cycles.
- room_broken must be settled (synchronous) before PICK. A room that breaks in the same cycle as PICK can be struck once, and the room FSM ignores strikes while broken.
- gap_cnt width is 4 bits; MIN_GAP + 3 must be ≤ 15.

## Structure

- Shared package/header nexys_starship_pkg holds:
  - state encodings: IDLE=4'b0001, COOL=4'b0010, PICK=4'b0100, STRIKE=4'b1000;
  - room indices: ROOM_TR=0, ROOM_BR=1, ROOM_LR=2, ROOM_RR=3;
  - the LFSR mask constant.
- One sub-module, nexys_starship_lfsr16 (ports: Clk, Reset, seed parameter, q[15:0]). The LFSR is instantiated there. The rotate-priority target pick stays inline.

## Test plan

- Reset low mid-COOL → next sample: q_Idle=1, strike_count=0, strike_hex=0, room_strike=0.
- Force the LFSR via seed so lfsr[1:0]=2, MIN_GAP=2, gap=2+2=4; play_flag, room_broken=0 → four ticks, then room_strike=4'b0100 exactly 2 Clk cycles after the 4th tick, 1 cycle wide, strike_count=1.
- room_broken=4'b0110 with cand=1 → target=3 (room_strike=4'b1000); room_broken=4'b1111 → remains in PICK with no pulse until bit 0 clears, then room_strike=4'b0001 two cycles later.
- Seed chosen so lfsr[7:4]=0 in PICK → strike_hex=4'hF; strike_hex stays unchanged through COOL and IDLE.
- gameover_ctrl during PICK → IDLE next cycle, no pulse, strike_hex unchanged; gameover during STRIKE → pulse still seen, then IDLE.
- 300 strikes with a forced-short gap → strike_count saturates at 8'd255; return to IDLE clears it to 0.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship hazard generator: state encodings,
// room indices and the LFSR feedback mask.
package nexys_starship_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_COOL   = 4'b0010,
      ST_PICK   = 4'b0100,
      ST_STRIKE = 4'b1000
   } hazard_state_t;

   localparam logic [1:0] ROOM_TR = 2'd0;
   localparam logic [1:0] ROOM_BR = 2'd1;
   localparam logic [1:0] ROOM_LR = 2'd2;
   localparam logic [1:0] ROOM_RR = 2'd3;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   // A zero combo would be unrepairable, so it is replaced by all-ones.
   function automatic logic [3:0] nonzero_hex(input logic [3:0] nib);
      return (nib == 4'h0) ? 4'hF : nib;
   endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it maps to 1.
module nexys_starship_lfsr16
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)
(
   input  logic        Clk,
   input  logic        Reset,
   output logic [15:0] q
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) q <= SEED_EFF;
      else        q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
   end

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// Hazard generator: waits a random cooldown, picks an unbroken room starting at a
// random index, and sends it a one-cycle strike pulse with a nonzero repair combo.
module nexys_starship_hazard_gen
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned MIN_GAP   = 2,
   parameter logic [1:0]  GAP_MASK  = 2'b11
)
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       gameover_ctrl,
   input  logic       timer_tick,
   input  logic [3:0] room_broken,
   output logic [3:0] room_strike,
   output logic [3:0] strike_hex,
   output logic [7:0] strike_count,
   output logic       q_Idle,
   output logic       q_Cool,
   output logic       q_Pick,
   output logic       q_Strike
);

   hazard_state_t state;
   logic [15:0]   lfsr;
   logic [3:0]    gap_cnt;
   logic [3:0]    gap_load;
   logic [1:0]    target;
   logic [1:0]    pick_room;
   logic [1:0]    idx;
   logic          pick_found;
   logic          lfsr_unused;

   nexys_starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .q     (lfsr)
   );

   assign lfsr_unused = ^{lfsr[15:8], lfsr[3:2]};
   assign gap_load    = 4'(MIN_GAP) + {2'b00, lfsr[1:0] & GAP_MASK};

   // Rotate-priority search: offset 0 from the random candidate wins, so scan downwards.
   always_comb begin
      pick_found = 1'b0;
      pick_room  = 2'd0;
      idx        = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = lfsr[1:0] + 2'(k);
         if (!room_broken[idx]) begin
            pick_found = 1'b1;
            pick_room  = idx;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= ST_IDLE;
         gap_cnt      <= 4'd0;
         target       <= ROOM_TR;
         strike_hex   <= 4'h0;
         strike_count <= 8'd0;
      end else if (gameover_ctrl && (state != ST_IDLE)) begin
         state        <= ST_IDLE;
         strike_count <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               strike_count <= 8'd0;
               if (play_flag && !gameover_ctrl) begin
                  state   <= ST_COOL;
                  gap_cnt <= gap_load;
               end
            end
            ST_COOL: begin
               if (timer_tick) begin
                  if (gap_cnt == 4'd1) state   <= ST_PICK;
                  else                 gap_cnt <= gap_cnt - 4'd1;
               end
            end
            ST_PICK: begin
               if (pick_found) begin
                  target     <= pick_room;
                  strike_hex <= nonzero_hex(lfsr[7:4]);
                  state      <= ST_STRIKE;
               end
            end
            ST_STRIKE: begin
               if (strike_count != 8'hFF) strike_count <= strike_count + 8'd1;
               gap_cnt <= gap_load;
               state   <= ST_COOL;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strike pulse: high for the single STRIKE cycle; strike_hex is valid on the same
   // cycle and the room samples both on the closing edge (no ready/back-pressure).
   assign room_strike = (state == ST_STRIKE) ? (4'b0001 << target) : 4'b0000;
   assign q_Idle      = (state == ST_IDLE);
   assign q_Cool      = (state == ST_COOL);
   assign q_Pick      = (state == ST_PICK);
   assign q_Strike    = (state == ST_STRIKE);

endmodule
